// File: rtl/fir_folded_param.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fir_folded_param: single-MAC folded FIR with programmable taps, rounding and
// output saturation.  Rev 1.0
// -----------------------------------------------------------------------------
module fir_folded_param #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = 8,
  parameter int FRAC = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DW-1:0]             x,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic [OW-1:0]             y,
  output logic                      valid,
  output logic                      sat,
  output logic                      ready
);

  localparam int KW = $clog2(TAPS);
  localparam int AW = DW + CW + KW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [KW:0]          TAPS_V = (KW+1)'(TAPS);
  localparam logic [KW-1:0]        K_LAST = KW'(TAPS - 1);
  localparam logic signed [AW:0]   Y_MAX  = (AW+1)'(2**(OW-1) - 1);
  localparam logic signed [AW:0]   Y_MIN  = ~Y_MAX;

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic signed [DW-1:0]    r_d [TAPS];
  logic signed [CW-1:0]    r_c [TAPS];
  logic [KW-1:0]           r_k;
  logic signed [AW-1:0]    r_acc;
  logic signed [DW+CW-1:0] w_prod;
  logic signed [AW:0]      w_rnd;
  logic signed [AW:0]      w_shift;
  logic                    w_hi;
  logic                    w_lo;
  logic                    w_coef_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_next = S_MAC;
      S_MAC:   if (r_k == K_LAST) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (r_state == S_IDLE);
  end

  assign w_prod    = r_c[r_k] * r_d[r_k];
  assign w_coef_ok = coef_we && ready && ({1'b0, coef_addr} < TAPS_V);

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  generate
    if (FRAC > 0) begin : g_rnd
      localparam logic signed [AW:0] RND = (AW+1)'(1) <<< (FRAC - 1);
      assign w_rnd = {r_acc[AW-1], r_acc} + RND;
    end else begin : g_no_rnd
      assign w_rnd = {r_acc[AW-1], r_acc};
    end
  endgenerate

  assign w_shift = w_rnd >>> FRAC;
  assign w_hi    = (w_shift > Y_MAX);
  assign w_lo    = (w_shift < Y_MIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_d[i] <= '0;
        r_c[i] <= '0;
      end
      r_k   <= '0;
      r_acc <= '0;
      y     <= '0;
      valid <= 1'b0;
      sat   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (w_coef_ok) r_c[coef_addr] <= coef_data;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            for (int i = TAPS - 1; i > 0; i--) r_d[i] <= r_d[i-1];
            r_d[0] <= $signed(x);
            r_acc  <= '0;
            r_k    <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + {{KW{w_prod[DW+CW-1]}}, w_prod};
          r_k   <= r_k + 1'b1;
        end
        S_OUT: begin
          valid <= 1'b1;
          sat   <= w_hi | w_lo;
          if (w_hi)      y <= Y_MAX[OW-1:0];
          else if (w_lo) y <= Y_MIN[OW-1:0];
          else           y <= w_shift[OW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_folded_param.md
# fir_folded_param

Parametrised single-MAC folded FIR filter: the next generation of the team's fixed 8-tap folded FIR, generalised in tap count, data and coefficient widths, and output scaling. It adds run-time programmable coefficients, round-half-up scaling, output saturation with a flag, and a ready/valid sample handshake. It sits between the sample source and the downstream consumer, one sample in and one filtered sample out per TAPS+2 cycles.

## Interface
- DW, 8: input sample width, signed two's complement
- CW, 8: coefficient width, signed
- TAPS, 8: number of taps, ≥2
- OW, 8: output width, signed
- FRAC, 7: right-shift applied to the accumulator before saturation, 0 ≤ FRAC < DW+CW
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous and active-low
- en  in  1  sample strobe; x is accepted when en && ready
- x  in  DW  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index to write
- coef_data  in  CW  coefficient value
- y  out  OW  filtered, rounded, saturated output (registered)
- valid  out  1  one-cycle pulse: y holds a new result
- sat  out  1  set with valid when y was clipped (registered)
- ready  out  1  high in IDLE: block accepts a sample or a coefficient write

## Operation
- Filter: y[n] = sat(round(sum over k=0..TAPS-1 of c[k]*d[k]) >> FRAC). d[0] is the newest sample.
- Accumulator width: AW = DW+CW+clog2(TAPS), signed, with no internal overflow possible.
- Round: add 2^(FRAC-1) when FRAC>0, then arithmetic shift right by FRAC.
- Saturate: clip to [-2^(OW-1), 2^(OW-1)-1]. sat=1 when clipping occurred.
- States:
  - IDLE: ready=1. On en, go to MAC.
  - MAC: runs TAPS cycles, index k = 0..TAPS-1.
  - OUT: one cycle, then back to IDLE.
- Edge with en && ready in IDLE:
  - delay line shifts: d[k] ← d[k-1], d[0] ← x.
  - acc ← 0, k ← 0, state ← MAC.
- MAC: each edge does acc ← acc + c[k]*d[k] and k ← k+1. After the edge with k=TAPS-1, state ← OUT.
- OUT edge: y, sat ← scaled acc; valid ← 1; state ← IDLE.
- Coefficient write: accepted only when coef_we && ready. c[coef_addr] ← coef_data.
  - Writes while busy are ignored.
  - coef_addr ≥ TAPS is ignored.
- en and coef_we in the same IDLE cycle: both take effect. The sample starting in that cycle uses the new coefficient.
- en while ready=0 is ignored; no sample is queued.

## Timing
- Reset values:
  - state IDLE, so ready=1.
  - y=0, valid=0, sat=0.
  - acc=0, all d[k]=0, all c[k]=0.
- Reset mid-operation (rst low at any edge, any state): all registers return to their reset values. No valid is produced for the interrupted sample.
- Latency: sample accepted at edge E0. MAC edges are E1..E_TAPS, OUT is E_TAPS+1. valid=1 in the cycle after E_TAPS+1.
- ready falls after E0 and returns high together with valid.
- Throughput: one sample per TAPS+2 cycles. With en held high, the next sample is accepted in the valid cycle.
- valid is high for exactly one cycle. y and sat hold their value until the next OUT edge.

## Test plan
- Reset, then load c[k]=16·k (0..112) and feed x=64 followed by seven zeros at full rate.
  - Required y: 0,8,16,24,32,40,48,56, each with sat=0.
  - Then one more zero → y=0.
- Load all c=127 and feed a step x=100.
  - First sample: y=99, sat=0.
  - Eighth sample: y=127, sat=1.
- Load all c=127 and feed x=-128 repeatedly.
  - Eighth sample: y=-128, sat=1.
  - Check ready low for exactly TAPS+1 cycles per sample.
- Pulse en during MAC, and coef_we during MAC.
  - Required: no extra sample accepted, coefficients unchanged.
  - Output sequence is identical to the no-glitch run.
- Drive rst low for one cycle at MAC step k=3.
  - Required: valid stays 0, ready=1 on the next cycle, y=0.
  - The next impulse reproduces the test-1 sequence from y=0.
- Simultaneous coef_we (addr 0, data 127) and en with x=64 in IDLE, with all other c=0 → y=64.
